// File: rtl/elevator_pkg.sv
// Shared types and call-mask helpers for the elevator car controller.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    DOOR,
    HALT
  } state_t;

  localparam int unsigned MAX_FLOORS = 16;
  localparam int unsigned MAX_FW     = 4;

  // True when any call bit lies strictly above floor.
  function automatic logic any_above(input logic [MAX_FLOORS-1:0] mask,
                                     input logic [MAX_FW-1:0]     floor);
    logic [MAX_FLOORS-1:0] upto;
    upto = MAX_FLOORS'(1) << floor;
    upto = upto | (upto - MAX_FLOORS'(1));
    return |(mask & ~upto);
  endfunction

  // True when any call bit lies strictly below floor.
  function automatic logic any_below(input logic [MAX_FLOORS-1:0] mask,
                                     input logic [MAX_FW-1:0]     floor);
    return |(mask & ((MAX_FLOORS'(1) << floor) - MAX_FLOORS'(1)));
  endfunction

endpackage

// File: rtl/tick_counter.sv
// Modulo-MAX enable counter; done flags the enable that completes a full period.
module tick_counter #(
  parameter int unsigned MAX = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic done
);

  localparam int unsigned CW = (MAX > 1) ? $clog2(MAX) : 1;

  logic [CW-1:0] count;
  logic          at_max;

  assign at_max = (count == CW'(MAX - 1));
  assign done   = en && at_max;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  count <= '0;
    else if (clr)  count <= '0;
    else if (en)   count <= at_max ? '0 : count + CW'(1);
  end

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN-order elevator car controller with travel/door timing and call mask.
// Optional emergency stop is enabled by defining ELEVATOR_EMERGENCY_STOP_EN.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter  int unsigned FLOORS          = 4,
  parameter  int unsigned TICKS_PER_FLOOR = 8,
  parameter  int unsigned DOOR_TICKS      = 6,
  localparam int unsigned FW              = $clog2(FLOORS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tick,
  input  logic              call_valid,
  input  logic [FW-1:0]     call_floor,
  input  logic              stop_req,
  output logic [FW-1:0]     current_floor,
  output logic              dir_up,
  output logic              moving,
  output logic              door_open,
  output logic              halted,
  output logic [FLOORS-1:0] pending,
  output logic              arrive
);

  state_t                state;
  logic                  stop_go;
  logic [MAX_FLOORS-1:0] pend_ext;
  logic [MAX_FW-1:0]     cur4, nxt4;
  logic [FW-1:0]         next_floor;
  logic                  ahead_cur, behind_cur, ahead_next;
  logic                  at_top_cur, at_bot_cur, at_top_next, at_bot_next;
  logic                  call_ok, door_restart;
  logic [FLOORS-1:0]     set_mask, clr_mask;
  logic                  travel_en, travel_clr, travel_done;
  logic                  door_en, door_clr, door_done;

`ifdef ELEVATOR_EMERGENCY_STOP_EN
  assign stop_go = stop_req;
`else
  logic unused_stop;
  assign unused_stop = stop_req;
  assign stop_go     = 1'b0;
`endif

  assign pend_ext   = MAX_FLOORS'(pending);
  assign next_floor = dir_up ? current_floor + FW'(1) : current_floor - FW'(1);
  assign cur4       = MAX_FW'(current_floor);
  assign nxt4       = MAX_FW'(next_floor);

  assign ahead_cur  = dir_up ? any_above(pend_ext, cur4) : any_below(pend_ext, cur4);
  assign behind_cur = dir_up ? any_below(pend_ext, cur4) : any_above(pend_ext, cur4);
  assign ahead_next = dir_up ? any_above(pend_ext, nxt4) : any_below(pend_ext, nxt4);

  assign at_top_cur  = (current_floor == FW'(FLOORS - 1));
  assign at_bot_cur  = (current_floor == '0);
  assign at_top_next = (next_floor == FW'(FLOORS - 1));
  assign at_bot_next = (next_floor == '0);

  assign call_ok      = call_valid && (32'(call_floor) < FLOORS);
  assign door_restart = (state == DOOR) && call_valid && (call_floor == current_floor) && !stop_go;

  // Counters only advance in their own state, so HALT freezes both; IDLE clears them.
  assign travel_en  = (state == MOVE) && tick && !stop_go;
  assign travel_clr = (state == IDLE);
  assign door_en    = (state == DOOR) && tick && !stop_go;
  assign door_clr   = (state == IDLE) || door_restart;

  tick_counter #(.MAX(TICKS_PER_FLOOR)) u_travel (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (travel_en),
    .clr     (travel_clr),
    .done    (travel_done)
  );

  tick_counter #(.MAX(DOOR_TICKS)) u_door (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (door_en),
    .clr     (door_clr),
    .done    (door_done)
  );

  // Clearing wins over setting, so a call landing on the arrival cycle is absorbed.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (call_ok && !door_restart) set_mask[call_floor] = 1'b1;
    if (!stop_go) begin
      if (state == IDLE && pending[current_floor])
        clr_mask[current_floor] = 1'b1;
      else if (state == MOVE && travel_done && pending[next_floor])
        clr_mask[next_floor] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      current_floor <= '0;
      dir_up        <= 1'b1;
      moving        <= 1'b0;
      door_open     <= 1'b0;
      halted        <= 1'b0;
      arrive        <= 1'b0;
      pending       <= '0;
    end else begin
      arrive  <= 1'b0;
      pending <= (pending | set_mask) & ~clr_mask;
      if (stop_go) begin
        state     <= HALT;
        halted    <= 1'b1;
        moving    <= 1'b0;
        door_open <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (pending[current_floor]) begin
              state     <= DOOR;
              door_open <= 1'b1;
              arrive    <= 1'b1;
            end else if (ahead_cur) begin
              state  <= MOVE;
              moving <= 1'b1;
            end else if (behind_cur) begin
              state  <= MOVE;
              moving <= 1'b1;
              dir_up <= ~dir_up;
            end
          end
          MOVE: begin
            if (travel_done) begin
              current_floor <= next_floor;
              if (pending[next_floor]) begin
                state     <= DOOR;
                moving    <= 1'b0;
                door_open <= 1'b1;
                arrive    <= 1'b1;
              end else if (!ahead_next) begin
                state  <= IDLE;
                moving <= 1'b0;
                if (at_top_next)      dir_up <= 1'b0;
                else if (at_bot_next) dir_up <= 1'b1;
              end
            end
          end
          DOOR: begin
            if (!door_restart && door_done) begin
              state     <= IDLE;
              door_open <= 1'b0;
              if (at_top_cur)      dir_up <= 1'b0;
              else if (at_bot_cur) dir_up <= 1'b1;
            end
          end
          default: begin
            state  <= IDLE;
            halted <= 1'b0;
            if (at_top_cur)      dir_up <= 1'b0;
            else if (at_bot_cur) dir_up <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_elevator_scheduler.sv
// Scoreboarded bench for elevator_scheduler: expected arrivals queued at call time.
module tb_elevator_scheduler;

  localparam int unsigned FLOORS = 5;
  localparam int unsigned TPF    = 8;
  localparam int unsigned DT     = 6;
  localparam int unsigned FW     = $clog2(FLOORS);

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              tick = 1'b0;
  logic              call_valid = 1'b0;
  logic [FW-1:0]     call_floor = '0;
  logic              stop_req = 1'b0;
  logic [FW-1:0]     current_floor;
  logic              dir_up, moving, door_open, halted, arrive;
  logic [FLOORS-1:0] pending;

  elevator_scheduler #(
    .FLOORS          (FLOORS),
    .TICKS_PER_FLOOR (TPF),
    .DOOR_TICKS      (DT)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .tick          (tick),
    .call_valid    (call_valid),
    .call_floor    (call_floor),
    .stop_req      (stop_req),
    .current_floor (current_floor),
    .dir_up        (dir_up),
    .moving        (moving),
    .door_open     (door_open),
    .halted        (halted),
    .pending       (pending),
    .arrive        (arrive)
  );

  always #5 clk = ~clk;

  // One tick every fourth cycle.
  int tph = 0;
  always @(posedge clk) begin
    #1;
    tph  = (tph == 3) ? 0 : tph + 1;
    tick = (tph == 0);
  end

  typedef struct {
    int   floor;
    int   mticks;
    int   dticks;
    logic dir;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   errors = 0;
  int   checks = 0;
  int   move_ticks = 0;
  int   door_ticks = 0;
  int   exp_dt = DT;
  logic prev_door = 1'b0;

  task automatic push_exp(input int f, input int m, input int d, input logic dir);
    exp_t e;
    e.floor = f; e.mticks = m; e.dticks = d; e.dir = dir;
    sb.push_back(e);
  endtask

  // Arrival monitor: pops the scoreboard on each arrive pulse, checks dwell on door close.
  always @(negedge clk) begin
    if (!reset_n) begin
      move_ticks = 0;
      door_ticks = 0;
      prev_door  = 1'b0;
    end else begin
      if (arrive === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL arrive_unexpected: floor=%0d, no arrival expected", current_floor);
        end else begin
          cur    = sb.pop_front();
          exp_dt = cur.dticks;
          checks++;
          if (current_floor !== FW'(cur.floor)) begin
            errors++;
            $display("FAIL arrive_floor: got %0d expected %0d", current_floor, cur.floor);
          end
          checks++;
          if (move_ticks !== cur.mticks) begin
            errors++;
            $display("FAIL travel_ticks: got %0d expected %0d (floor %0d)", move_ticks, cur.mticks, cur.floor);
          end
          checks++;
          if (dir_up !== cur.dir) begin
            errors++;
            $display("FAIL arrive_dir: got %0b expected %0b (floor %0d)", dir_up, cur.dir, cur.floor);
          end
        end
        checks++;
        if (!(door_open === 1'b1 && prev_door === 1'b0)) begin
          errors++;
          $display("FAIL arrive_edge: door_open=%0b prev=%0b expected 1/0", door_open, prev_door);
        end
        move_ticks = 0;
        door_ticks = 0;
      end
      if (prev_door === 1'b1 && door_open === 1'b0 && halted !== 1'b1) begin
        checks++;
        if (door_ticks !== exp_dt) begin
          errors++;
          $display("FAIL door_dwell: got %0d expected %0d", door_ticks, exp_dt);
        end
      end
      if (moving === 1'b1 && tick === 1'b1)    move_ticks++;
      if (door_open === 1'b1 && tick === 1'b1) door_ticks++;
      prev_door = door_open;
    end
  end

  task automatic drive_call(input int f);
    @(posedge clk); #1;
    call_valid = 1'b1;
    call_floor = FW'(f);
    @(posedge clk); #1;
    call_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && moving === 1'b0 && door_open === 1'b0 &&
          halted === 1'b0 && pending === '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_moving(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (moving === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_door(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (door_open === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (current_floor !== '0 || dir_up !== 1'b1) begin
      errors++;
      $display("FAIL reset_floor_dir: floor=%0d dir=%0b expected 0/1", current_floor, dir_up);
    end
    checks++;
    if ({moving, door_open, halted, arrive} !== 4'b0000 || pending !== '0) begin
      errors++;
      $display("FAIL reset_status: m=%0b d=%0b h=%0b a=%0b p=%b expected all 0",
               moving, door_open, halted, arrive, pending);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_single_call();
    bit ok;
    push_exp(2, 2 * TPF, DT, 1'b1);
    drive_call(2);
    @(negedge clk);
    checks++;
    if (pending !== 5'b00100 || moving !== 1'b0) begin
      errors++;
      $display("FAIL call_latency: pending=%b moving=%0b expected 00100/0", pending, moving);
    end
    @(negedge clk);
    checks++;
    if (moving !== 1'b1) begin
      errors++;
      $display("FAIL move_start: moving=%0b expected 1", moving);
    end
    wait_idle(1000, ok);
    checks++;
    if (!ok || current_floor !== 3'd2) begin
      errors++;
      $display("FAIL single_idle: ok=%0b floor=%0d expected 1/2", ok, current_floor);
    end
  endtask

  task automatic test_scan_order();
    bit ok;
    push_exp(0, 2 * TPF, DT, 1'b0);
    drive_call(0);
    wait_idle(1000, ok);
    checks++;
    if (!ok || dir_up !== 1'b1) begin
      errors++;
      $display("FAIL ground_dir: ok=%0b dir=%0b expected 1/1", ok, dir_up);
    end
    push_exp(1, TPF, DT, 1'b1);
    drive_call(1);
    wait_door(500, ok);
    checks++;
    if (!ok || current_floor !== 3'd1) begin
      errors++;
      $display("FAIL scan_door1: ok=%0b floor=%0d expected 1/1", ok, current_floor);
    end
    push_exp(3, 2 * TPF, DT, 1'b1);
    push_exp(0, 3 * TPF, DT, 1'b0);
    drive_call(0);
    drive_call(3);
    wait_idle(2000, ok);
    checks++;
    if (!ok || current_floor !== 3'd0 || dir_up !== 1'b1) begin
      errors++;
      $display("FAIL scan_end: ok=%0b floor=%0d dir=%0b expected 1/0/1", ok, current_floor, dir_up);
    end
  endtask

  task automatic test_out_of_range();
    drive_call(5);
    drive_call(7);
    @(negedge clk);
    checks++;
    if (pending !== '0) begin
      errors++;
      $display("FAIL range_pending: got %b expected 00000", pending);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (moving !== 1'b0 || door_open !== 1'b0 || current_floor !== '0) begin
      errors++;
      $display("FAIL range_idle: m=%0b d=%0b floor=%0d expected 0/0/0", moving, door_open, current_floor);
    end
  endtask

  task automatic test_top_boundary();
    bit ok;
    push_exp(4, 4 * TPF, DT, 1'b1);
    drive_call(4);
    wait_idle(1500, ok);
    checks++;
    if (!ok || current_floor !== 3'd4 || dir_up !== 1'b0) begin
      errors++;
      $display("FAIL top_dir: ok=%0b floor=%0d dir=%0b expected 1/4/0", ok, current_floor, dir_up);
    end
    push_exp(2, 2 * TPF, DT, 1'b0);
    drive_call(2);
    wait_idle(1000, ok);
    checks++;
    if (!ok || current_floor !== 3'd2) begin
      errors++;
      $display("FAIL top_return: ok=%0b floor=%0d expected 1/2", ok, current_floor);
    end
  endtask

  task automatic test_door_restart();
    bit ok;
    int n;
    push_exp(2, 0, 4 + DT, 1'b0);
    drive_call(2);
    wait_door(50, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL restart_open: door_open=%0b expected 1", door_open);
    end
    n = 0;
    do begin @(posedge clk); n++; end while (door_ticks < 4 && n < 200);
    checks++;
    if (door_ticks !== 4) begin
      errors++;
      $display("FAIL restart_reach: door_ticks=%0d expected 4", door_ticks);
    end
    #1;
    call_valid = 1'b1;
    call_floor = 3'd2;
    @(posedge clk); #1;
    call_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (pending[2] !== 1'b0 || door_open !== 1'b1) begin
      errors++;
      $display("FAIL restart_pending: pending=%b door=%0b expected bit2=0/1", pending, door_open);
    end
    wait_idle(500, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL restart_idle: idle=0 expected 1");
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    push_exp(3, TPF, DT, 1'b1);
    push_exp(4, TPF, DT, 1'b1);
    @(posedge clk); #1;
    call_valid = 1'b1; call_floor = 3'd3;
    @(posedge clk); #1;
    call_floor = 3'd3;
    @(posedge clk); #1;
    call_floor = 3'd4;
    @(posedge clk); #1;
    call_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (pending !== 5'b11000) begin
      errors++;
      $display("FAIL b2b_pending: got %b expected 11000", pending);
    end
    wait_idle(1000, ok);
    checks++;
    if (!ok || current_floor !== 3'd4 || dir_up !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: ok=%0b floor=%0d dir=%0b expected 1/4/0", ok, current_floor, dir_up);
    end
  endtask

  task automatic test_stop();
    bit ok;
    int n;
`ifdef ELEVATOR_EMERGENCY_STOP_EN
    push_exp(3, 3 + TPF, DT, 1'b0);
`else
    push_exp(3, TPF, DT, 1'b0);
`endif
    push_exp(0, 3 * TPF, DT, 1'b0);
    drive_call(3);
    wait_moving(50, ok);
    n = 0;
    do begin @(posedge clk); n++; end while (move_ticks < 3 && n < 200);
    checks++;
    if (!ok || move_ticks !== 3) begin
      errors++;
      $display("FAIL stop_reach: ok=%0b move_ticks=%0d expected 1/3", ok, move_ticks);
    end
    #1;
    stop_req = 1'b1;
    @(negedge clk);
    checks++;
`ifdef ELEVATOR_EMERGENCY_STOP_EN
    if (halted !== 1'b1 || moving !== 1'b0 || door_open !== 1'b0) begin
      errors++;
      $display("FAIL stop_enter: h=%0b m=%0b d=%0b expected 1/0/0", halted, moving, door_open);
    end
`else
    if (halted !== 1'b0 || moving !== 1'b1) begin
      errors++;
      $display("FAIL stop_ignored: h=%0b m=%0b expected 0/1", halted, moving);
    end
`endif
    drive_call(0);
    @(negedge clk);
    checks++;
    if (pending[0] !== 1'b1) begin
      errors++;
      $display("FAIL stop_latch: pending=%b expected bit0=1", pending);
    end
`ifdef ELEVATOR_EMERGENCY_STOP_EN
    repeat (12) @(negedge clk);
    checks++;
    if (halted !== 1'b1 || moving !== 1'b0 || current_floor !== 3'd4) begin
      errors++;
      $display("FAIL stop_hold: h=%0b m=%0b floor=%0d expected 1/0/4", halted, moving, current_floor);
    end
`endif
    @(posedge clk); #1;
    stop_req = 1'b0;
`ifdef ELEVATOR_EMERGENCY_STOP_EN
    @(negedge clk);
    checks++;
    if (halted !== 1'b0 || moving !== 1'b0 || current_floor !== 3'd4) begin
      errors++;
      $display("FAIL stop_release: h=%0b m=%0b floor=%0d expected 0/0/4", halted, moving, current_floor);
    end
    @(negedge clk);
    checks++;
    if (moving !== 1'b1) begin
      errors++;
      $display("FAIL stop_resume: moving=%0b expected 1", moving);
    end
`endif
    wait_idle(1500, ok);
    checks++;
    if (!ok || current_floor !== 3'd0) begin
      errors++;
      $display("FAIL stop_end: ok=%0b floor=%0d expected 1/0", ok, current_floor);
    end
  endtask

  task automatic test_reset_mid_travel();
    bit ok;
    int n;
    drive_call(4);
    wait_moving(50, ok);
    n = 0;
    do begin @(posedge clk); n++; end while (move_ticks < 10 && n < 200);
    #2;
    checks++;
    if (!ok || current_floor !== 3'd1 || moving !== 1'b1) begin
      errors++;
      $display("FAIL midtravel_pos: ok=%0b floor=%0d moving=%0b expected 1/1/1", ok, current_floor, moving);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (current_floor !== '0 || dir_up !== 1'b1 || moving !== 1'b0 || door_open !== 1'b0 ||
        halted !== 1'b0 || arrive !== 1'b0 || pending !== '0) begin
      errors++;
      $display("FAIL async_reset: floor=%0d dir=%0b m=%0b d=%0b h=%0b a=%0b p=%b expected 0/1/0/0/0/0/0",
               current_floor, dir_up, moving, door_open, halted, arrive, pending);
    end
    sb.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (current_floor !== '0 || moving !== 1'b0 || pending !== '0) begin
      errors++;
      $display("FAIL post_reset: floor=%0d m=%0b p=%b expected 0/0/0", current_floor, moving, pending);
    end
  endtask

  initial begin
    test_reset();
    test_single_call();
    test_scan_order();
    test_out_of_range();
    test_top_boundary();
    test_door_restart();
    test_back_to_back();
    test_stop();
    test_reset_mid_travel();
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

endmodule
